// File: rtl/stopwatch_pkg.sv
// Shared state codes and BCD limits for the stopwatch control path.
// The state codes double as the enable code decoded by the tick counter.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    localparam logic [3:0] BCD_ONES_MAX = 4'd9;
    localparam logic [3:0] BCD_TENS_MAX = 4'd5;

    function automatic logic [3:0] bcd_next(input logic [3:0] d, input logic [3:0] max);
        return (d == max) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Multi-flop synchronizer plus rising-edge detector for one button level.
// A button already high when reset releases must be released before it can edge.
module btn_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_edge
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] vld_q, vld_d;
    logic                   prev_q, prev_d;
    logic                   armed_q, armed_d;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // vld tracks how far real samples have propagated after reset, so the
    // cleared chain is never mistaken for an observed "released" level.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], btn_in};
        vld_d   = {vld_q[SYNC_STAGES-2:0], 1'b1};
        prev_d  = sync_out;
        armed_d = armed_q | (vld_q[SYNC_STAGES-1] & ~sync_out);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            vld_q   <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            vld_q   <= vld_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
        end
    end

    assign btn_edge = sync_out & ~prev_q & armed_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear state machine and BCD mm:ss counter for the stopwatch.
// en is the state register itself, so it only ever carries the three legal codes.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_MINUTES = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    input  logic       sec_tick,
    output logic [1:0] en,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       wrap_pulse
);

    localparam logic [3:0] MIN_TENS_TOP = 4'(MAX_MINUTES / 10);
    localparam logic [3:0] MIN_ONES_TOP = 4'(MAX_MINUTES % 10);

    logic   ss_edge, clr_edge;
    state_t state_q, state_d;
    logic [3:0] sec_ones_q, sec_ones_d, sec_tens_q, sec_tens_d;
    logic [3:0] min_ones_q, min_ones_d, min_tens_q, min_tens_d;
    logic   wrap_q, wrap_d;
    logic   tick_ok, at_max;

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
        .clk      (clk),
        .rst_n    (reset),
        .btn_in   (btn_start_stop),
        .btn_edge (ss_edge)
    );

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clr_sync (
        .clk      (clk),
        .rst_n    (reset),
        .btn_in   (btn_clear),
        .btn_edge (clr_edge)
    );

    always_comb begin
        state_d = state_q;
        if (clr_edge) begin
            state_d = ST_IDLE;
        end else if (ss_edge) begin
            unique case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Ticks follow the registered state, so a tick landing with the pause edge still counts.
    assign tick_ok = sec_tick && (state_q == ST_RUN) && !clr_edge;
    assign at_max  = (min_tens_q == MIN_TENS_TOP) && (min_ones_q == MIN_ONES_TOP) &&
                     (sec_tens_q == BCD_TENS_MAX) && (sec_ones_q == BCD_ONES_MAX);

    always_comb begin
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        wrap_d     = 1'b0;
        if (clr_edge || (tick_ok && at_max)) begin
            sec_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            min_ones_d = 4'd0;
            min_tens_d = 4'd0;
            wrap_d     = !clr_edge;
        end else if (tick_ok) begin
            sec_ones_d = bcd_next(sec_ones_q, BCD_ONES_MAX);
            if (sec_ones_q == BCD_ONES_MAX) begin
                sec_tens_d = bcd_next(sec_tens_q, BCD_TENS_MAX);
                if (sec_tens_q == BCD_TENS_MAX) begin
                    min_ones_d = bcd_next(min_ones_q, BCD_ONES_MAX);
                    if (min_ones_q == BCD_ONES_MAX)
                        min_tens_d = min_tens_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
            wrap_q     <= wrap_d;
        end
    end

    assign en         = state_q;
    assign running    = (state_q == ST_RUN);
    assign sec_ones   = sec_ones_q;
    assign sec_tens   = sec_tens_q;
    assign min_ones   = min_ones_q;
    assign min_tens   = min_tens_q;
    assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: vector table plus hand-timed corner sequences.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_ss = 1'b0;
    logic       btn_clr = 1'b0;
    logic       sec_tick = 1'b0;
    logic [1:0] en;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       running, wrap_pulse;
    logic [15:0] tm;

    int passed = 0;
    int total = 0;
    int wrap_cnt = 0;
    int inv_bad = 0;
    logic wrap_prev = 1'b0;

    stopwatch_ctrl #(.SYNC_STAGES(2), .MAX_MINUTES(59)) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_start_stop (btn_ss),
        .btn_clear      (btn_clr),
        .sec_tick       (sec_tick),
        .en             (en),
        .sec_ones       (sec_ones),
        .sec_tens       (sec_tens),
        .min_ones       (min_ones),
        .min_tens       (min_tens),
        .running        (running),
        .wrap_pulse     (wrap_pulse)
    );

    always #5 clk = ~clk;
    assign tm = {min_tens, min_ones, sec_tens, sec_ones};

    always @(negedge clk) begin
        if (reset) begin
            if (en == 2'b11) inv_bad++;
            if (wrap_pulse && wrap_prev) inv_bad++;
            if (sec_ones > 4'd9 || sec_tens > 4'd5 || min_ones > 4'd9 || min_tens > 4'd5) inv_bad++;
            if (wrap_pulse) wrap_cnt++;
        end
        wrap_prev = wrap_pulse;
    end

    typedef enum {OP_SS, OP_CLR, OP_TICK} op_t;
    typedef struct {
        op_t        op;
        int         n;
        logic [1:0] en;
        logic [15:0] tm;
        int         wraps;
    } vec_t;

    vec_t vecs[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            sec_tick = 1'b1;
            step();
            sec_tick = 1'b0;
            repeat (gap - 1) step();
        end
    endtask

    task automatic press_ss();
        btn_ss = 1'b1;
        repeat (4) step();
        btn_ss = 1'b0;
        repeat (4) step();
    endtask

    task automatic press_clr();
        btn_clr = 1'b1;
        repeat (4) step();
        btn_clr = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        vecs[0] = '{OP_TICK, 65, 2'b01, 16'h0105, 0};
        vecs[1] = '{OP_CLR,   0, 2'b00, 16'h0000, 0};
        vecs[2] = '{OP_SS,    0, 2'b01, 16'h0000, 0};
        vecs[3] = '{OP_TICK,  3, 2'b01, 16'h0003, 0};
        vecs[4] = '{OP_SS,    0, 2'b10, 16'h0003, 0};
        vecs[5] = '{OP_TICK,  5, 2'b10, 16'h0003, 0};
        vecs[6] = '{OP_SS,    0, 2'b01, 16'h0003, 0};
        vecs[7] = '{OP_TICK,  1, 2'b01, 16'h0004, 0};
        vecs[8] = '{OP_TICK,  3, 2'b01, 16'h0007, 0};

        // Reset state
        repeat (5) step();
        check("rst_en", 32'(en), 32'h0);
        check("rst_time", 32'(tm), 32'h0);
        check("rst_running", 32'(running), 32'h0);
        check("rst_wrap", 32'(wrap_pulse), 32'h0);
        reset = 1'b1;
        repeat (5) step();

        // Start latency: sampled at edge N, state changes at N+2
        btn_ss = 1'b1;
        step();
        check("start_lat_n", 32'(en), 32'h0);
        step();
        check("start_lat_n1", 32'(en), 32'h0);
        step();
        check("start_lat_n2", 32'(en), 32'h1);
        check("start_running", 32'(running), 32'h1);
        step();
        btn_ss = 1'b0;
        repeat (4) step();
        check("start_held_once", 32'(en), 32'h1);
        check("start_time", 32'(tm), 32'h0);

        for (int i = 0; i < 9; i++) begin
            case (vecs[i].op)
                OP_SS:   press_ss();
                OP_CLR:  press_clr();
                default: ticks(vecs[i].n, 10);
            endcase
            check($sformatf("vec%0d_en", i), 32'(en), 32'(vecs[i].en));
            check($sformatf("vec%0d_time", i), 32'(tm), 32'(vecs[i].tm));
            check($sformatf("vec%0d_wraps", i), 32'(wrap_cnt), 32'(vecs[i].wraps));
        end

        // Clear, start_stop and tick all land on the same edge: clear wins
        btn_ss = 1'b1;
        btn_clr = 1'b1;
        step();
        step();
        sec_tick = 1'b1;
        step();
        sec_tick = 1'b0;
        check("simul_en", 32'(en), 32'h0);
        check("simul_time", 32'(tm), 32'h0);
        btn_ss = 1'b0;
        btn_clr = 1'b0;
        repeat (4) step();
        check("simul_after_en", 32'(en), 32'h0);

        // Tick coinciding with the RUN->PAUSE edge is counted
        press_ss();
        ticks(7, 10);
        check("pre_pause_time", 32'(tm), 32'h0007);
        btn_ss = 1'b1;
        step();
        step();
        sec_tick = 1'b1;
        step();
        sec_tick = 1'b0;
        check("pause_tick_en", 32'(en), 32'h2);
        check("pause_tick_time", 32'(tm), 32'h0008);
        btn_ss = 1'b0;
        repeat (4) step();
        press_ss();
        check("resume_en", 32'(en), 32'h1);

        // Wrap at 59:59
        ticks(3591, 2);
        check("pre_wrap_time", 32'(tm), 32'h5959);
        check("pre_wrap_cnt", 32'(wrap_cnt), 32'h0);
        sec_tick = 1'b1;
        step();
        sec_tick = 1'b0;
        check("wrap_time", 32'(tm), 32'h0000);
        check("wrap_pulse_hi", 32'(wrap_pulse), 32'h1);
        check("wrap_en", 32'(en), 32'h1);
        step();
        check("wrap_pulse_lo", 32'(wrap_pulse), 32'h0);
        check("wrap_cnt", 32'(wrap_cnt), 32'h1);

        // Asynchronous reset mid-run with start_stop held through release
        ticks(754, 2);
        check("pre_rst_time", 32'(tm), 32'h1234);
        #2;
        reset = 1'b0;
        btn_ss = 1'b1;
        #1;
        check("async_rst_time", 32'(tm), 32'h0);
        check("async_rst_en", 32'(en), 32'h0);
        check("async_rst_running", 32'(running), 32'h0);
        repeat (3) step();
        #2;
        reset = 1'b1;
        repeat (8) step();
        check("held_btn_no_edge", 32'(en), 32'h0);
        btn_ss = 1'b0;
        repeat (4) step();
        check("released_no_edge", 32'(en), 32'h0);
        press_ss();
        check("repress_en", 32'(en), 32'h1);

        check("invariants", 32'(inv_bad), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control and display-count end of the stopwatch datapath.
- Turns start/stop and clear buttons into the 2-bit enable code that drives the seconds tick counter (00 idle, 01 count, 10 pause).
- Consumes the one-cycle second tick returned by that counter and keeps elapsed time as BCD mm:ss digits for the display mux.

Parameters:
- SYNC_STAGES, 2: synchronizer flops per button input; legal range 2..3.
- MAX_MINUTES, 59: highest minute value; the step past MAX_MINUTES:59 wraps to 00:00.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- btn_start_stop, input, 1: debounced, asynchronous level; each rising edge toggles run/pause.
- btn_clear, input, 1: debounced, asynchronous level; a rising edge returns to idle and zeroes the time.
- sec_tick, input, 1: one-cycle pulse from the tick counter marking one elapsed second.
- en, output, 2: enable code to the tick counter; 00 IDLE, 01 RUN, 10 PAUSE; 11 is never driven.
- sec_ones, output, 4: BCD seconds units, 0..9.
- sec_tens, output, 4: BCD seconds tens, 0..5.
- min_ones, output, 4: BCD minutes units, 0..9.
- min_tens, output, 4: BCD minutes tens, 0..MAX_MINUTES/10.
- running, output, 1: high while in RUN.
- wrap_pulse, output, 1: one-cycle pulse when the time rolls over to 00:00.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE, en = 00.
  - All digits = 0, running = 0, wrap_pulse = 0.
  - All synchronizer and edge flops clear to 0.
  - A button already held high at reset release does not produce an edge until it is released and pressed again.
- Input conditioning:
  - Each button passes through SYNC_STAGES flops, then an edge register.
  - edge = sync_out & ~prev.
  - With SYNC_STAGES = 2: a button first sampled high at rising edge N changes state/en at edge N+2.
  - Holding a button produces exactly one edge.
- State machine (registered; en and running decoded from the state register):
  - IDLE + start_stop edge -> RUN.
  - RUN + start_stop edge -> PAUSE.
  - PAUSE + start_stop edge -> RUN.
  - Any state + clear edge -> IDLE, and all digits are zeroed on the same edge.
  - Clear and start_stop edges in the same cycle: clear wins; the start_stop edge is discarded.
- Time counting:
  - sec_tick is accepted only when the registered state is RUN; ticks in IDLE or PAUSE are ignored.
  - A tick in the same cycle as a RUN->PAUSE edge is counted.
  - A tick in the same cycle as a clear edge is discarded.
  - Increment is a BCD cascade:
    - sec_ones 9 -> 0 carries to sec_tens.
    - sec_tens 5 -> 0 carries to min_ones.
    - min_ones 9 -> 0 carries to min_tens.
    - At MAX_MINUTES:59, the next tick loads 00:00 and asserts wrap_pulse for exactly that one cycle; state stays RUN.
  - Digits update on the clock edge that samples sec_tick high; there is no extra latency.
- Invariants:
  - Digits never leave their BCD range.
  - en never equals 11.
  - wrap_pulse is never high for two consecutive cycles.

Decomposition:
- Shared package stopwatch_pkg holds:
  - State encoding localparams ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_PAUSE = 2'b10. These are the same codes the tick counter decodes on its en input.
  - BCD limit constants (9, 5).
- One sub-module, btn_edge_sync: SYNC_STAGES-deep synchronizer plus rising-edge detector with active-low async reset. Instantiated twice, once per button.
- The FSM and the BCD cascade stay in stopwatch_ctrl.

Test Plan:
- Reset and start: hold reset low 5 cycles, release; pulse btn_start_stop high for 4 cycles -> en = 00 until edge N+2, then en = 01 and running = 1; all digits remain 0.
- Counting and carry: in RUN, apply 65 sec_tick pulses spaced 10 cycles apart -> digits read min_ones = 1, sec_tens = 0, sec_ones = 5 (01:05); no wrap_pulse.
- Pause hold-off: after 3 ticks, press start_stop -> en = 10; apply 5 ticks -> digits stay 00:03; press again -> en = 01; one more tick -> 00:04.
- Simultaneous events: in RUN at 00:07, assert both buttons so their edges coincide with a sec_tick -> next state IDLE, en = 00, digits 00:00. Separately, a tick in the same cycle as the RUN->PAUSE edge -> count advances to 00:08.
- Wrap-around: preload by ticking to 59:59 (MAX_MINUTES = 59) -> the next tick gives 00:00, wrap_pulse high for exactly 1 cycle, en stays 01.
- Reset mid-operation: at 12:34 in RUN, drive reset low between clock edges -> outputs clear immediately without waiting for clk; after release with btn_start_stop still held high -> no transition until release and re-press.
